// File: rtl/wb_check_monitor.sv
// Writeback monitor: compares core register-file writes against a programmed table of (rd, value) pairs.
// Optional timeout between matches is built when WB_CHECK_TIMEOUT_EN is defined.
module wb_check_monitor #(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int REG_AW         = 5,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CW = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              exp_we_i,
    input  logic [IW-1:0]     exp_idx_i,
    input  logic [REG_AW-1:0] exp_rd_i,
    input  logic [XLEN-1:0]   exp_data_i,
    input  logic              start_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [1:0]        fail_code_o,
    output logic [IW-1:0]     fail_idx_o,
    output logic [XLEN-1:0]   fail_data_o,
    output logic [CW-1:0]     checks_done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cd_q, cd_d;
    logic [1:0]        fcode_q, fcode_d;
    logic [IW-1:0]     fidx_q, fidx_d;
    logic [XLEN-1:0]   fdata_q, fdata_d;
    logic              busy_q, done_q, pass_q, fail_q;

    logic [REG_AW-1:0] tbl_rd_q   [NUM_CHECKS];
    logic [XLEN-1:0]   tbl_data_q [NUM_CHECKS];
    logic              hit;

`ifdef WB_CHECK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0]     timer_q, timer_d;
`endif

    // Table is deliberately not reset so it survives a run abort.
    always_ff @(posedge clk_i) begin
        if (exp_we_i && state_q != S_RUN && int'(exp_idx_i) < NUM_CHECKS) begin
            tbl_rd_q[exp_idx_i]   <= exp_rd_i;
            tbl_data_q[exp_idx_i] <= exp_data_i;
        end
    end

    assign hit = wb_en_i && (wb_rd_i != '0) && (wb_rd_i == tbl_rd_q[ptr_q]);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cd_d    = cd_q;
        fcode_d = fcode_q;
        fidx_d  = fidx_q;
        fdata_d = fdata_q;
`ifdef WB_CHECK_TIMEOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            S_RUN: begin
                if (hit) begin
                    if (wb_data_i == tbl_data_q[ptr_q]) begin
                        cd_d = cd_q + CW'(1);
`ifdef WB_CHECK_TIMEOUT_EN
                        timer_d = '0;
`endif
                        if (ptr_q == IW'(NUM_CHECKS - 1)) state_d = S_PASS;
                        else                              ptr_d   = ptr_q + IW'(1);
                    end else begin
                        state_d = S_FAIL;
                        fcode_d = 2'b01;
                        fidx_d  = ptr_q;
                        fdata_d = wb_data_i;
                    end
                end
`ifdef WB_CHECK_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_FAIL;
                    fcode_d = 2'b10;
                    fidx_d  = ptr_q;
                    fdata_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            default: begin
                if (start_i) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                    cd_d    = '0;
                    fcode_d = 2'b00;
                    fidx_d  = '0;
                    fdata_d = '0;
`ifdef WB_CHECK_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cd_q    <= '0;
            fcode_q <= 2'b00;
            fidx_q  <= '0;
            fdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
`ifdef WB_CHECK_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cd_q    <= cd_d;
            fcode_q <= fcode_d;
            fidx_q  <= fidx_d;
            fdata_q <= fdata_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass_q  <= (state_d == S_PASS);
            fail_q  <= (state_d == S_FAIL);
`ifdef WB_CHECK_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign fail_o        = fail_q;
    assign fail_code_o   = fcode_q;
    assign fail_idx_o    = fidx_q;
    assign fail_data_o   = fdata_q;
    assign checks_done_o = cd_q;

endmodule

// File: tb/tb_wb_check_monitor.sv
// Directed bench for wb_check_monitor with a 3-entry table and an 8-cycle timeout.
module tb_wb_check_monitor;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        exp_we_i;
    logic [1:0]  exp_idx_i;
    logic [4:0]  exp_rd_i;
    logic [31:0] exp_data_i;
    logic        start_i;
    logic        wb_en_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        busy_o, done_o, pass_o, fail_o;
    logic [1:0]  fail_code_o;
    logic [1:0]  fail_idx_o;
    logic [31:0] fail_data_o;
    logic [1:0]  checks_done_o;

    int n_tests = 0;
    int n_fail  = 0;

    wb_check_monitor #(
        .XLEN(32), .NUM_CHECKS(3), .REG_AW(5), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .exp_we_i(exp_we_i), .exp_idx_i(exp_idx_i), .exp_rd_i(exp_rd_i), .exp_data_i(exp_data_i),
        .start_i(start_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
        .fail_code_o(fail_code_o), .fail_idx_o(fail_idx_o), .fail_data_o(fail_data_o),
        .checks_done_o(checks_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_tbl(input logic [1:0] idx, input logic [4:0] rd, input logic [31:0] data);
        exp_we_i = 1'b1; exp_idx_i = idx; exp_rd_i = rd; exp_data_i = data;
        tick();
        exp_we_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_en_i = 1'b1; wb_rd_i = rd; wb_data_i = data;
        tick();
        wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    endtask

    task automatic chk_verdict(input string tag, input logic p, input logic f, input logic [1:0] cd);
        chk({tag, "_pass"}, 32'(pass_o), 32'(p));
        chk({tag, "_fail"}, 32'(fail_o), 32'(f));
        chk({tag, "_done"}, 32'(done_o), 32'(p | f));
        chk({tag, "_busy"}, 32'(busy_o), 32'(0));
        chk({tag, "_cd"}, 32'(checks_done_o), 32'(cd));
    endtask

    initial begin
        reset_i = 1'b0; exp_we_i = 1'b0; exp_idx_i = '0; exp_rd_i = '0; exp_data_i = '0;
        start_i = 1'b0; wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        tick(); tick();
        reset_i = 1'b1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_pass", 32'(pass_o), 0);
        chk("rst_fail", 32'(fail_o), 0);
        chk("rst_code", 32'(fail_code_o), 0);
        chk("rst_cd", 32'(checks_done_o), 0);

        wr_tbl(2'd0, 5'd1, 32'h17);
        wr_tbl(2'd1, 5'd2, 32'h29);
        wr_tbl(2'd2, 5'd3, 32'h01);

        // Clean pass
        do_start();
        chk("p1_busy", 32'(busy_o), 1);
        wb(5'd1, 32'h17);
        chk("p1_cd1", 32'(checks_done_o), 1);
        wb(5'd2, 32'h29);
        chk("p1_busy_mid", 32'(busy_o), 1);
        wb(5'd3, 32'h01);
        chk_verdict("p1", 1'b1, 1'b0, 2'd3);

        // Data mismatch on the last entry
        do_start();
        chk("m_clr_done", 32'(done_o), 0);
        wb(5'd1, 32'h17);
        wb(5'd2, 32'h29);
        wb(5'd3, 32'h29);
        chk_verdict("m", 1'b0, 1'b1, 2'd2);
        chk("m_code", 32'(fail_code_o), 1);
        chk("m_idx", 32'(fail_idx_o), 2);
        chk("m_data", 32'(fail_data_o), 32'h29);

        // x0, unrelated registers and out-of-order targets are ignored
        do_start();
        chk("i_clr_code", 32'(fail_code_o), 0);
        wb(5'd0, 32'hFFFF);
        wb(5'd2, 32'h1234);
        wb(5'd1, 32'h17);
        wb(5'd5, 32'h5);
        wb(5'd0, 32'hFFFF);
        wb(5'd2, 32'h29);
        wb(5'd5, 32'h5);
        wb(5'd3, 32'h01);
        chk_verdict("i", 1'b1, 1'b0, 2'd3);

`ifdef WB_CHECK_TIMEOUT_EN
        // Silence: verdict appears in the 9th cycle after start is sampled
        do_start();
        for (int k = 0; k < 7; k++) tick();
        chk("t_not_yet", 32'(fail_o), 0);
        chk("t_busy8", 32'(busy_o), 1);
        tick();
        chk_verdict("t", 1'b0, 1'b1, 2'd0);
        chk("t_code", 32'(fail_code_o), 2);
        chk("t_idx", 32'(fail_idx_o), 0);
        chk("t_data", 32'(fail_data_o), 0);

        // Match on the threshold cycle wins and restarts the timer
        do_start();
        for (int k = 0; k < 7; k++) tick();
        wb(5'd1, 32'h17);
        chk("tm_busy", 32'(busy_o), 1);
        chk("tm_cd", 32'(checks_done_o), 1);
        for (int k = 0; k < 7; k++) tick();
        chk("tm_still", 32'(fail_o), 0);
        tick();
        chk("tm_fail", 32'(fail_o), 1);
        chk("tm_code", 32'(fail_code_o), 2);
        chk("tm_idx", 32'(fail_idx_o), 1);
`else
        do_start();
        for (int k = 0; k < 100; k++) tick();
        chk("nt_busy", 32'(busy_o), 1);
        chk("nt_code", 32'(fail_code_o), 0);
`endif

        // Reset mid-run after one match aborts without a verdict
        reset_i = 1'b0; tick(); reset_i = 1'b1;
        do_start();
        wb(5'd1, 32'h17);
        reset_i = 1'b0; tick(); reset_i = 1'b1;
        chk("r_busy", 32'(busy_o), 0);
        chk("r_done", 32'(done_o), 0);
        chk("r_cd", 32'(checks_done_o), 0);
        do_start();
        wb(5'd1, 32'h17);
        wb(5'd2, 32'h29);
        wb(5'd3, 32'h01);
        chk_verdict("r2", 1'b1, 1'b0, 2'd3);

        // Table write and restart requests during RUN are ignored
        do_start();
        wb(5'd1, 32'h17);
        wr_tbl(2'd1, 5'd2, 32'h99);
        do_start();
        chk("w_cd", 32'(checks_done_o), 1);
        chk("w_busy", 32'(busy_o), 1);
        wb(5'd2, 32'h29);
        wb(5'd3, 32'h01);
        chk_verdict("w", 1'b1, 1'b0, 2'd3);

        // Table write together with start: run uses the new entry
        exp_we_i = 1'b1; exp_idx_i = 2'd0; exp_rd_i = 5'd1; exp_data_i = 32'h55;
        start_i = 1'b1;
        tick();
        exp_we_i = 1'b0; start_i = 1'b0;
        wb(5'd1, 32'h17);
        chk("ws_fail", 32'(fail_o), 1);
        chk("ws_data", 32'(fail_data_o), 32'h17);
        chk("ws_idx", 32'(fail_idx_o), 0);
        do_start();
        wb(5'd1, 32'h55);
        wb(5'd2, 32'h29);
        wb(5'd3, 32'h01);
        chk_verdict("ws2", 1'b1, 1'b0, 2'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_check_monitor.md
# wb_check_monitor

Parametrised, self-checking writeback monitor for the RV32I core verification flow. Holds a programmable table of expected (destination register, value) pairs and watches the core's register-file write port. Checks, in order, that each targeted register receives its expected value. Reports pass or fail, with the failing entry, so instruction tests finish with a single verdict instead of manual `$monitor` inspection. Sits beside the core in the bench, or on-chip as a debug block, and taps the writeback port only.

## Interface
- XLEN, 32, data width of the writeback and expected values
- NUM_CHECKS, 4, depth of the expected-value table (≥1)
- REG_AW, 5, register address width
- TIMEOUT_CYCLES, 64, maximum RUN cycles allowed between successive matches (≥2)
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset
- exp_we  in  1  write one table entry
- exp_idx  in  clog2(NUM_CHECKS)  table entry index
- exp_rd  in  REG_AW  expected destination register
- exp_data  in  XLEN  expected value
- start  in  1  begin a checking run
- wb_en  in  1  core register-file write enable
- wb_rd  in  REG_AW  core write address
- wb_data  in  XLEN  core write data
- busy  out  1  high in RUN
- done  out  1  sticky verdict valid
- pass  out  1  all NUM_CHECKS entries matched
- fail  out  1  mismatch or timeout
- fail_code  out  2  00 none, 01 data mismatch, 10 timeout
- fail_idx  out  clog2(NUM_CHECKS)  table entry being checked at failure
- fail_data  out  XLEN  wb_data that caused the mismatch (0 on timeout)
- checks_done  out  clog2(NUM_CHECKS+1)  number of entries matched so far

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset (reset=0 at an edge) forces IDLE. It clears the pointer, timer, checks_done and all outputs to 0. Table contents are not cleared.
- Reset mid-run aborts the run; there is no verdict.
- The table can be written in IDLE, PASS and FAIL. exp_we in RUN is ignored.
- start in IDLE, PASS or FAIL → RUN, with the pointer, timer, checks_done, done, pass, fail, fail_code, fail_idx and fail_data cleared. start in RUN is ignored.
- A wb_en in the same cycle as start is not checked.
- In RUN, a qualifying write is wb_en=1, wb_rd≠0 and wb_rd==exp_rd[ptr]. Writes to x0, and writes to other registers, are ignored.
- Qualifying write with wb_data==exp_data[ptr]: the entry matches, checks_done and ptr increment, and the timer clears. If this was the last entry (ptr==NUM_CHECKS-1), the state goes to PASS.
- Qualifying write with wb_data≠exp_data[ptr]: the state goes to FAIL, with fail_code=01, fail_idx=ptr and fail_data=wb_data.
- PASS: done=1, pass=1. FAIL: done=1, fail=1. Both states hold until start or reset.
- pass and fail are never high together. busy is high only in RUN.

## Timing
- Every output is registered. A match or mismatch in cycle N is visible on the outputs in cycle N+1.
- busy rises one cycle after start is sampled.
- The timer increments on each RUN cycle without a match. When the timer equals TIMEOUT_CYCLES-1 and there is no match in that cycle, the state goes to FAIL, with fail_code=10, fail_idx=ptr and fail_data=0.
- A match in the same cycle as the timeout threshold wins: the match is taken and the timer clears.
- The pointer never wraps. After PASS it is reset only by start.
- A table write and a start in the same cycle: the write lands, and the run uses the new entry.

## Configuration
- WB_CHECK_TIMEOUT_EN defined: the timer and timeout behaviour are built as described.
- WB_CHECK_TIMEOUT_EN not defined: no timer is built, RUN waits indefinitely for qualifying writes, and fail_code=10 is never produced. The TIMEOUT_CYCLES parameter is unused.

## Test plan
- Table {x1=0x17, x2=0x29, x3=0x01}, NUM_CHECKS=3, start, then writebacks x1=0x17, x2=0x29, x3=0x01 → pass=1, done=1, checks_done=3 one cycle after the x3 write.
- Same table, x3 written as 0x29 → fail=1, fail_code=01, fail_idx=2, fail_data=0x29, checks_done=2.
- Interleave writes to x0=0xFFFF and x5=0x5 between the expected writes → ignored; verdict is pass.
- With WB_CHECK_TIMEOUT_EN and TIMEOUT_CYCLES=8, start and send no writebacks → fail_code=10 on the 9th cycle after start is sampled, fail_idx=0. Without the macro → busy stays 1 after 100 cycles.
- reset=0 for one edge mid-run after one match → next cycle busy=0, done=0, checks_done=0. A new start with a matching sequence then passes.
- exp_we during RUN changing entry 1 to 0x99 → ignored; the original 0x29 still passes. start during RUN → no restart; checks_done keeps its value.
